// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Operands are captured at start; the result is computed and committed on the final busy edge.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       MDUControl,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDUout
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               is_long, is_div, mul_signed, div_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, den, quo_mag, rem_mag;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign is_long = (MDUControl >= OP_MULT && MDUControl <= OP_DIVU) ||
                     (MDUControl >= OP_MADD && MDUControl <= OP_MSUBU);
    assign is_div  = (MDUControl == OP_DIV) || (MDUControl == OP_DIVU);

    // Arithmetic on the captured operands only; live inputs never reach the result path.
    assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;
    assign acc   = {hi_q, lo_q};

    // Sign-magnitude divide: most-negative / -1 wraps naturally to most-negative, remainder 0.
    assign div_signed = (op_q == OP_DIV);
    assign a_neg   = div_signed & a_q[WIDTH-1];
    assign b_neg   = div_signed & b_q[WIDTH-1];
    assign a_mag   = a_neg ? -a_q : a_q;
    assign b_mag   = b_neg ? -b_q : b_q;
    assign den     = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign quo_mag = a_mag / den;
    assign rem_mag = a_mag % den;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT, OP_MULTU: {res_hi, res_lo} = prod;
            OP_MADD, OP_MADDU: {res_hi, res_lo} = acc + prod;
            OP_MSUB, OP_MSUBU: {res_hi, res_lo} = acc - prod;
            OP_DIV, OP_DIVU: begin
                if (b_q == '0) begin
                    res_lo = '1;
                    res_hi = a_q;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
                    res_hi = a_neg ? -rem_mag : rem_mag;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && is_long) begin
                    state_d = RUN;
                    op_d    = MDUControl;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end else if (!start && MDUControl == OP_MTHI) begin
                    hi_d = A;
                end else if (!start && MDUControl == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MDUout = (MDUControl == OP_MFHI) ? hi_q :
                    (MDUControl == OP_MFLO) ? lo_q : '0;
endmodule
